// File: rtl/wb_scheduler.sv
// Write-back port scheduler: grants one result source per cycle and registers the
// write-cycle mux select, write enable and destination. WB_SCHED_RR_EN selects round-robin.
module wb_scheduler #(
    parameter int unsigned NSRC  = 7,
    parameter int unsigned REG_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [NSRC-1:0]       i_wb_req,
    input  logic [NSRC*REG_W-1:0] i_wb_dest,
    input  logic                  i_wb_hold,
    output logic [NSRC-1:0]       o_wb_grant,
    output logic [2:0]            o_mem_to_reg,
    output logic                  o_reg_write,
    output logic [REG_W-1:0]      o_write_reg,
    output logic                  o_wb_busy
);

    logic [NSRC-1:0]  w_elig;
    logic [NSRC-1:0]  w_grant;
    logic             w_found;
    logic [2:0]       w_gnt_idx;
    logic [REG_W-1:0] w_gnt_dest;

    logic [2:0]       r_mem_to_reg;
    logic             r_reg_write;
    logic [REG_W-1:0] r_write_reg;
    logic             r_wb_busy;

`ifdef WB_SCHED_RR_EN
    logic [2:0]       r_rr_ptr;
`endif

    always_comb begin
        int j;
        j          = 0;
        // Reset and hold both suppress grants in the same cycle.
        w_elig     = i_wb_req & ~{NSRC{i_wb_hold}} & {NSRC{i_reset_n}};
        w_grant    = '0;
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_dest = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
`ifdef WB_SCHED_RR_EN
            j = int'(r_rr_ptr) + k;
            if (j >= int'(NSRC)) begin
                j = j - int'(NSRC);
            end
`else
            j = k;
`endif
            if (!w_found && w_elig[j]) begin
                w_found    = 1'b1;
                w_grant[j] = 1'b1;
                w_gnt_idx  = 3'(j);
                w_gnt_dest = i_wb_dest[j*int'(REG_W) +: REG_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mem_to_reg <= '0;
            r_write_reg  <= '0;
            r_reg_write  <= 1'b0;
            r_wb_busy    <= 1'b0;
        end else begin
            if (w_found) begin
                r_mem_to_reg <= w_gnt_idx;
                r_write_reg  <= w_gnt_dest;
                // A grant to $0 releases the source without writing.
                r_reg_write  <= (w_gnt_dest != '0);
            end else begin
                r_reg_write  <= 1'b0;
            end
            r_wb_busy <= |(i_wb_req & ~w_grant);
        end
    end

`ifdef WB_SCHED_RR_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_gnt_idx == 3'(NSRC - 1)) ? 3'd0 : w_gnt_idx + 3'd1;
        end
    end
`endif

    assign o_wb_grant   = w_grant;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_reg_write  = r_reg_write;
    assign o_write_reg  = r_write_reg;
    assign o_wb_busy    = r_wb_busy;

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed plan cases plus random traffic
// against a cycle-level reference model (fixed priority or round-robin via WB_SCHED_RR_EN).
module tb_wb_scheduler;

    localparam int NSRC  = 7;
    localparam int REG_W = 5;

    logic                  clk;
    logic                  reset_n;
    logic [NSRC-1:0]       wb_req;
    logic [NSRC*REG_W-1:0] wb_dest;
    logic                  wb_hold;
    logic [NSRC-1:0]       wb_grant;
    logic [2:0]            mem_to_reg;
    logic                  reg_write;
    logic [REG_W-1:0]      write_reg;
    logic                  wb_busy;

    wb_scheduler #(
        .NSRC  (NSRC),
        .REG_W (REG_W)
    ) u_dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_wb_req     (wb_req),
        .i_wb_dest    (wb_dest),
        .i_wb_hold    (wb_hold),
        .o_wb_grant   (wb_grant),
        .o_mem_to_reg (mem_to_reg),
        .o_reg_write  (reg_write),
        .o_write_reg  (write_reg),
        .o_wb_busy    (wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_ptr  = 0;
    int m_mtr  = 0;
    int m_wr   = 0;
    int m_rw   = 0;
    int m_busy = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winning source index, or -1 when nothing is eligible.
    function automatic int pick(input logic [NSRC-1:0] req, input logic hold, input logic rst_n);
        int j;
        if (!rst_n || hold) return -1;
        for (int k = 0; k < NSRC; k++) begin
`ifdef WB_SCHED_RR_EN
            j = (m_ptr + k) % NSRC;
`else
            j = k;
`endif
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic int dest_of(input logic [NSRC*REG_W-1:0] d, input int w);
        return int'(d[w*REG_W +: REG_W]);
    endfunction

    // One clock cycle: drive, check grant, model the edge, check registered outputs.
    task automatic step(input logic [NSRC-1:0] req, input logic [NSRC*REG_W-1:0] dest,
                        input logic hold, input logic rst_n);
        int w;
        logic [NSRC-1:0] exp_g;
        wb_req  = req;
        wb_dest = dest;
        wb_hold = hold;
        reset_n = rst_n;
        #1;
        w     = pick(req, hold, rst_n);
        exp_g = '0;
        if (w >= 0) exp_g[w] = 1'b1;
        check_eq("grant", 32'(wb_grant), 32'(exp_g));
        @(posedge clk);
        if (!rst_n) begin
            m_mtr = 0; m_wr = 0; m_rw = 0; m_busy = 0; m_ptr = 0;
        end else begin
            if (w >= 0) begin
                m_mtr = w;
                m_wr  = dest_of(dest, w);
                m_rw  = (m_wr != 0) ? 1 : 0;
                m_ptr = (w + 1) % NSRC;
            end else begin
                m_rw = 0;
            end
            m_busy = ((req & ~exp_g) != '0) ? 1 : 0;
        end
        @(negedge clk);
        check_eq("mem_to_reg", 32'(mem_to_reg), 32'(m_mtr));
        check_eq("write_reg", 32'(write_reg), 32'(m_wr));
        check_eq("reg_write", 32'(reg_write), 32'(m_rw));
        check_eq("wb_busy", 32'(wb_busy), 32'(m_busy));
    endtask

    function automatic logic [NSRC*REG_W-1:0] one_dest(input int idx, input int val);
        logic [NSRC*REG_W-1:0] d;
        d = '0;
        d[idx*REG_W +: REG_W] = REG_W'(val);
        return d;
    endfunction

    initial begin
        logic [NSRC*REG_W-1:0] d;
        logic [NSRC-1:0]       r;
        reset_n = 1'b0;
        wb_req  = '0;
        wb_dest = '0;
        wb_hold = 1'b0;
        @(negedge clk);

        // Reset with every source requesting
        step(7'h7F, {NSRC*REG_W{1'b1}}, 1'b0, 1'b0);
        step(7'h7F, {NSRC*REG_W{1'b1}}, 1'b0, 1'b0);

        // Single request, then idle to see reg_write drop with held select
        step(7'b0000010, one_dest(1, 9), 1'b0, 1'b1);
        check_eq("single_wr9", 32'(write_reg), 32'd9);
        step(7'b0000000, '0, 1'b0, 1'b1);

        // Grant to $0 is consumed without a write
        step(7'b1000000, one_dest(6, 0), 1'b0, 1'b1);
        check_eq("zero_mtr6", 32'(mem_to_reg), 32'd6);
        check_eq("zero_rw", 32'(reg_write), 32'd0);

        // Contention from reset
        step(7'b0001001, '0, 1'b0, 1'b0);
        d = one_dest(0, 4) | one_dest(3, 12);
        for (int i = 0; i < 4; i++) step(7'b0001001, d, 1'b0, 1'b1);

        // Hold blocks, release grants in the same cycle
        for (int i = 0; i < 3; i++) step(7'b0000100, one_dest(2, 31), 1'b1, 1'b1);
        step(7'b0000100, one_dest(2, 31), 1'b0, 1'b1);
        check_eq("hold_wr31", 32'(write_reg), 32'd31);

        // Reset right after a grant; contention afterwards shows the pointer restart
        step(7'b0010000, one_dest(4, 7), 1'b0, 1'b1);
        step(7'b0010000, one_dest(4, 7), 1'b1, 1'b0);
        check_eq("rst_mid_rw", 32'(reg_write), 32'd0);
        for (int i = 0; i < 3; i++) step(7'b0100010, one_dest(1, 3) | one_dest(5, 8), 1'b0, 1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            r = NSRC'($urandom);
            for (int s = 0; s < NSRC; s++) begin
                d[s*REG_W +: REG_W] = ($urandom_range(0, 3) == 0) ? '0 : REG_W'($urandom);
            end
            step(r, d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
